stc_psum_collector: RTL and testbench
=====================================

Name: stc_psum_collector

Overview:
- Downstream stage of the sparse tensor core. Consumes the fan-tree output bus: N_BUSLINE lanes plus a per-lane valid mask.
- Compacts the valid lanes of each accepted group into a circular buffer, in ascending lane order.
- Drains one word per cycle to the writeback path through a valid/ready handshake. Each word carries its source lane index and a group-last marker.

Parameters:
- N_BUSLINE, 62, number of fan-tree output lanes
- DW_DATA, 32, signed data width per lane
- DEPTH, 128, buffer entries; power of two and >= 2*N_BUSLINE
- W_LANE, $clog2(N_BUSLINE), lane-index width
- W_CNT, $clog2(DEPTH)+1, occupancy width

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- in_bus  input  N_BUSLINE*DW_DATA  lane data; lane i = bits [i*DW_DATA +: DW_DATA]
- in_mask  input  N_BUSLINE  per-lane valid (fan-tree out_valid)
- in_push  input  1  group strobe
- in_last  input  1  group closes an output tile
- in_ready  output  1  buffer can absorb a full group
- out_data  output  DW_DATA  head word
- out_lane  output  W_LANE  source lane of head word
- out_last  output  1  head word is the last word of a tile
- out_valid  output  1  head word valid
- out_ready  input  1  consumer accepts head word
- count  output  W_CNT  current occupancy
- err_overflow  output  1  sticky: push attempted while in_ready = 0
- err_empty_last  output  1  sticky: in_last carried by a zero-mask group

Behaviour:
- Reset (reset = 0, asynchronous):
  - wr_ptr, rd_ptr, count, err_overflow and err_empty_last clear to 0 immediately.
  - Outputs during reset: out_valid = 0, in_ready = 1, out_data/out_lane/out_last = 0.
  - Storage array is not reset.
  - Reset mid-drain discards all buffered words; nothing is emitted after release until a new push.
- in_ready = (DEPTH - count) >= N_BUSLINE. Combinational from the count register only; no dependence on in_push.
- Push accept: in_push & in_ready at a rising edge.
  - k = popcount(in_mask).
  - Set lane j is written to entry (wr_ptr + rank(j)) mod DEPTH, where rank(j) = number of set mask bits below j.
  - Each entry stores {data, lane j, last}. last = in_last only for the highest-indexed set lane; 0 for all others.
  - wr_ptr advances by k mod DEPTH (wrap-around).
- Zero-mask accepted push writes nothing. If in_last = 1 on that push, set err_empty_last.
- Push while in_ready = 0: the group is dropped, no state change, err_overflow set.
- Pop: out_valid & out_ready at a rising edge. rd_ptr advances by 1 mod DEPTH.
- Head outputs:
  - out_valid = (count != 0).
  - out_data, out_lane and out_last reflect entry rd_ptr.
  - Outputs are held stable while out_valid = 1 and out_ready = 0.
- Latency: a word accepted at edge t can appear at the head in the cycle after edge t (first-word latency 1).
- Simultaneous push and pop: count_next = count + k - pop. The pop reads the old head and is never blocked by a same-cycle push.
- Occupancy invariant: count never exceeds DEPTH, because in_ready gating guarantees that bound.
- Error flags are cleared only by reset.

Test Plan (N_BUSLINE=4, DEPTH=8, DW_DATA=32):
- Reset and basic push:
  - Stimulus: release reset; push mask 4'b1010, bus lanes {3:-7, 2:x, 1:5, 0:x}, in_last=1; out_ready held 1.
  - Required: out_valid rises the next cycle; words (5, lane 1, last 0) then (-7, lane 3, last 1); count returns to 0.
- Backpressure hold:
  - Stimulus: out_ready=0; push mask 4'b1111 twice (data 1..8).
  - Required: count = 8 and in_ready = 0; head holds 1/lane 0 unchanged for 5 cycles; a third push sets err_overflow and count stays 8.
- Wrap-around:
  - Stimulus: push 3 words and pop 3, then push mask 1111 twice, data 10..17, with out_ready=1.
  - Required: output order is 10..17 with lanes 0,1,2,3,0,1,2,3; no loss across the pointer wrap.
- Simultaneous push and pop:
  - Stimulus: count=2, out_ready=1, push mask 4'b0111 in the same cycle.
  - Required: count becomes 4; the popped word is the old head.
- Zero-mask last:
  - Stimulus: push mask 0 with in_last=1.
  - Required: count unchanged; err_empty_last = 1 and remains 1 until reset.
- Mid-operation reset:
  - Stimulus: count=5; assert reset between clock edges.
  - Required: out_valid=0 and count=0 immediately; in_ready=1; the first word after release comes from a new push.

Source files
------------

// File: rtl/stc_psum_collector.sv
// Partial-sum collector: packs the valid fan-tree lanes of each group into a
// circular buffer and drains one {data, lane, last} word per cycle.
module stc_psum_collector #(
  parameter int N_BUSLINE = 62,
  parameter int DW_DATA   = 32,
  parameter int DEPTH     = 128,
  parameter int W_LANE    = $clog2(N_BUSLINE),
  parameter int W_CNT     = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_BUSLINE*DW_DATA-1:0]   in_bus,
  input  logic [N_BUSLINE-1:0]           in_mask,
  input  logic                           in_push,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [DW_DATA-1:0]             out_data,
  output logic [W_LANE-1:0]              out_lane,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W_CNT-1:0]               count,
  output logic                           err_overflow,
  output logic                           err_empty_last
);

  localparam int W_PTR = $clog2(DEPTH);
  localparam int W_ENT = DW_DATA + W_LANE + 1;

  logic [W_ENT-1:0] r_mem [DEPTH];
  logic [W_PTR-1:0] r_wr_ptr;
  logic [W_PTR-1:0] r_rd_ptr;
  logic [W_CNT-1:0] r_count;
  logic             r_err_ovf;
  logic             r_err_el;

  logic [W_PTR-1:0]     w_rank  [N_BUSLINE];
  logic [W_PTR-1:0]     w_addr  [N_BUSLINE];
  logic [W_ENT-1:0]     w_entry [N_BUSLINE];
  logic [N_BUSLINE-1:0] w_is_top;
  logic [W_CNT-1:0]     w_k;
  logic [W_ENT-1:0]     w_head;
  logic                 w_push_acc;
  logic                 w_pop;

  // Exclusive prefix popcount: rank of each set lane within the group.
  always_comb begin
    logic [W_CNT-1:0] v_acc;
    v_acc = '0;
    for (int j = 0; j < N_BUSLINE; j++) begin
      w_rank[j] = v_acc[W_PTR-1:0];
      v_acc     = v_acc + W_CNT'(in_mask[j]);
    end
    w_k = v_acc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BUSLINE; gi++) begin : g_lane
      assign w_is_top[gi] = in_mask[gi] & ~|(in_mask >> (gi + 1));
      assign w_addr[gi]   = r_wr_ptr + w_rank[gi];
      assign w_entry[gi]  = {in_bus[gi*DW_DATA +: DW_DATA], W_LANE'(gi),
                             in_last & w_is_top[gi]};
    end
  endgenerate

  assign in_ready   = (r_count <= W_CNT'(DEPTH - N_BUSLINE));
  assign w_push_acc = in_push & in_ready;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid & out_ready;

  assign w_head   = r_mem[r_rd_ptr];
  assign out_data = out_valid ? w_head[W_ENT-1 -: DW_DATA] : '0;
  assign out_lane = out_valid ? w_head[W_LANE:1] : '0;
  assign out_last = out_valid & w_head[0];

  assign count          = r_count;
  assign err_overflow   = r_err_ovf;
  assign err_empty_last = r_err_el;

  // Ranks are distinct, so set lanes never collide on an entry.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      for (int j = 0; j < N_BUSLINE; j++) begin
        if (in_mask[j]) r_mem[w_addr[j]] <= w_entry[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_el  <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + w_k[W_PTR-1:0];
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (w_push_acc ? w_k : '0) - W_CNT'(w_pop);
      if (in_push && !in_ready)                         r_err_ovf <= 1'b1;
      if (w_push_acc && (in_mask == '0) && in_last)     r_err_el  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stc_psum_collector.sv
// Scoreboard bench for stc_psum_collector with N_BUSLINE=4, DEPTH=8.
module tb_stc_psum_collector;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int WL = 2;
  localparam int WC = 4;

  logic            clk;
  logic            reset;
  logic [N*DW-1:0] in_bus;
  logic [N-1:0]    in_mask;
  logic            in_push;
  logic            in_last;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [WL-1:0]   out_lane;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [WC-1:0]   count;
  logic            err_overflow;
  logic            err_empty_last;

  stc_psum_collector #(.N_BUSLINE(N), .DW_DATA(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .in_mask(in_mask),
    .in_push(in_push), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .err_overflow(err_overflow), .err_empty_last(err_empty_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [WL-1:0] lane;
    logic          last;
  } word_t;

  word_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    m_cnt = 0;
  logic  m_ovf = 1'b0;
  logic  m_eel = 1'b0;

  // One clock: score a pop against the queue, model the push, check state after the edge.
  task automatic step();
    logic  pop, acc;
    int    k;
    word_t e;
    pop = (m_cnt != 0) && out_ready;
    total++;
    if (out_valid !== (m_cnt != 0)) begin
      bad++; $display("FAIL out_valid: got %0b want %0b", out_valid, (m_cnt != 0));
    end
    if (pop) begin
      e = q.pop_front();
      total++;
      if ({out_data, out_lane, out_last} !== {e.data, e.lane, e.last}) begin
        bad++;
        $display("FAIL pop_word: got data=%0d lane=%0d last=%0b want data=%0d lane=%0d last=%0b",
                 $signed(out_data), out_lane, out_last, $signed(e.data), e.lane, e.last);
      end else begin
        $display("pop data=%0d lane=%0d last=%0b", $signed(out_data), out_lane, out_last);
      end
    end
    k = $countones(in_mask);
    acc = in_push && ((D - m_cnt) >= N);
    if (in_push && !acc) m_ovf = 1'b1;
    if (acc && k == 0 && in_last) m_eel = 1'b1;
    if (acc) begin
      int seen;
      seen = 0;
      for (int j = 0; j < N; j++) begin
        if (in_mask[j]) begin
          seen++;
          e.data = in_bus[j*DW +: DW];
          e.lane = WL'(j);
          e.last = in_last && (seen == k);
          q.push_back(e);
        end
      end
      $display("push mask=%b last=%0b k=%0d", in_mask, in_last, k);
    end
    @(posedge clk);
    m_cnt = m_cnt + (acc ? k : 0) - (pop ? 1 : 0);
    @(negedge clk);
    total++;
    if ({count, in_ready, err_overflow, err_empty_last} !==
        {WC'(m_cnt), ((D - m_cnt) >= N), m_ovf, m_eel}) begin
      bad++;
      $display("FAIL state: got count=%0d rdy=%0b ovf=%0b eel=%0b want count=%0d rdy=%0b ovf=%0b eel=%0b",
               count, in_ready, err_overflow, err_empty_last, m_cnt, ((D - m_cnt) >= N), m_ovf, m_eel);
    end
  endtask

  task automatic push(input logic [N-1:0] mask, input logic last,
                      input int d0, input int d1, input int d2, input int d3);
    in_bus  = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    in_mask = mask;
    in_last = last;
    in_push = 1'b1;
    step();
    in_push = 1'b0;
    in_mask = '0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    total++;
    if (q.size() != 0 || count !== '0) begin
      bad++; $display("FAIL drain: got left=%0d count=%0d want 0", q.size(), count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_push = 1'b0; in_mask = '0; in_last = 1'b0; in_bus = '0; out_ready = 1'b0;
    #12;
    total++;
    if ({out_valid, in_ready, count, out_data, out_lane, out_last, err_overflow, err_empty_last} !==
        {1'b1 ^ 1'b1, 1'b1, WC'(0), DW'(0), WL'(0), 3'b000}) begin
      bad++; $display("FAIL reset: got valid=%0b rdy=%0b count=%0d want 0 1 0", out_valid, in_ready, count);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(4'b1010, 1'b1, 99, 5, 77, -7);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd5) begin
      bad++; $display("FAIL latency: got valid=%0b data=%0d want 1 5", out_valid, $signed(out_data));
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(4'b1111, 1'b0, 1, 2, 3, 4);
    push(4'b1111, 1'b1, 5, 6, 7, 8);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_data !== 32'd1 || out_lane !== 2'd0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold: got data=%0d lane=%0d rdy=%0b want 1 0 0", out_data, out_lane, in_ready);
      end
    end
    push(4'b1111, 1'b0, 9, 9, 9, 9);
    total++;
    if (err_overflow !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL overflow: got ovf=%0b count=%0d want 1 8", err_overflow, count);
    end
    drain();
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    push(4'b0111, 1'b1, 100, 101, 102, 0);
    drain();
    out_ready = 1'b1;
    push(4'b1111, 1'b0, 10, 11, 12, 13);
    push(4'b1111, 1'b1, 14, 15, 16, 17);
    drain();
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    push(4'b0011, 1'b0, 20, 21, 0, 0);
    out_ready = 1'b1;
    push(4'b0111, 1'b1, 30, 31, 32, 0);
    total++;
    if (count !== 4'd4 || out_data !== 32'd21) begin
      bad++; $display("FAIL simul: got count=%0d head=%0d want 4 21", count, out_data);
    end
    drain();
  endtask

  task automatic test_zero_last();
    out_ready = 1'b0;
    push(4'b0000, 1'b1, 1, 2, 3, 4);
    for (int i = 0; i < 3; i++) step();
    total++;
    if (err_empty_last !== 1'b1 || count !== 4'd0) begin
      bad++; $display("FAIL zero_last: got eel=%0b count=%0d want 1 0", err_empty_last, count);
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    push(4'b1111, 1'b0, 40, 41, 42, 43);
    push(4'b0001, 1'b1, 44, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, count, in_ready, err_overflow, err_empty_last} !== {1'b0, WC'(0), 1'b1, 2'b00}) begin
      bad++; $display("FAIL midreset: got valid=%0b count=%0d rdy=%0b want 0 0 1", out_valid, count, in_ready);
    end
    q.delete(); m_cnt = 0; m_ovf = 1'b0; m_eel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    push(4'b0100, 1'b1, 0, 0, 50, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd50 || out_lane !== 2'd2 || out_last !== 1'b1) begin
      bad++; $display("FAIL post_reset: got valid=%0b data=%0d lane=%0d want 1 50 2", out_valid, out_data, out_lane);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_simultaneous();
    test_zero_last();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
